decode_buffer: RTL and testbench
================================

DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning number of enqueue and dequeue lanes (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of entries (power of two, DEPTH >= 2*LANES).
REQ-003 SHALL have parameter DW, default 128, meaning payload width of one decoded-instruction bundle.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port flush, input, 1 bit: synchronous discard of all contents.
REQ-007 SHALL have port in_valid, input, LANES bits: per-lane enqueue request.
REQ-008 SHALL have port in_data, input, LANES x DW: per-lane bundle.
REQ-009 SHALL have port in_ready, output, 1 bit: the buffer can accept a full LANES-wide group this cycle.
REQ-010 SHALL have port out_valid, output, LANES bits: lane i holds the i-th oldest entry.
REQ-011 SHALL have port out_data, output, LANES x DW: the oldest LANES entries, oldest in lane 0.
REQ-012 SHALL have port out_ready, input, LANES bits: consumer acceptance per lane.
REQ-013 SHALL have port count, output, clog2(DEPTH+1) bits: current occupancy.
REQ-014 SHALL have port pause, output, 1 bit: equal to !in_ready, used to stall fetch.

Function
REQ-015 SHALL accept all valid input lanes in a cycle only when in_ready=1; when in_ready=0, inputs SHALL be ignored, with no partial acceptance.
REQ-016 SHALL compute in_ready from registered state only: (DEPTH - count) >= LANES; it SHALL not depend on the same-cycle dequeue.
REQ-017 SHALL compact sparse in_valid lanes in ascending lane order into consecutive entries at the write pointer (e.g. in_valid=2'b10 writes lane 1 only, as one entry).
REQ-018 SHALL drive out_valid[i] = (count > i), with out_data[i] = entry at (rd_ptr + i) mod DEPTH, combinationally from storage.
REQ-019 SHALL dequeue k entries, where k is the number of leading lanes from lane 0 with out_valid & out_ready both set; any lane after the first unaccepted lane SHALL not dequeue, even if its ready is set.
REQ-020 SHALL make enqueued data visible on out_* no earlier than the cycle after the write edge, giving a minimum latency of 1 cycle.
REQ-021 SHALL update count as count + enq_num - k when enqueue and dequeue occur in the same cycle.
REQ-022 SHALL advance wr_ptr and rd_ptr modulo DEPTH, with wrap-around transparent to lane ordering.
REQ-023 On flush=1, SHALL set count, rd_ptr and wr_ptr to 0 at the next edge, and ignore same-cycle enqueue and dequeue; flush SHALL take priority over both.
REQ-024 SHALL leave stored data unchanged on flush or reset; only out_valid gating matters.
REQ-025 SHALL never exceed DEPTH entries, and SHALL never underflow; this holds by construction from REQ-016 and REQ-019.

Reset
REQ-026 On rst=1 at an edge, SHALL set count=0, rd_ptr=0, wr_ptr=0, which gives out_valid=0, in_ready=1 and pause=0 in the following cycle.
REQ-027 SHALL give rst priority over flush, enqueue and dequeue; reset asserted mid-operation SHALL discard all entries.

Structure
REQ-028 SHALL take the LANES and DEPTH defaults, and the decoded-bundle typedef (pc, inst, aluop, alusel, imm, reg read/write enables and addresses), from shared package decode_pkg; DW SHALL equal the bundle width.
REQ-029 SHALL place lane compaction and enqueue-count logic in one sub-module, lane_compact (in_valid to per-lane write offsets plus enq_num).
REQ-030 SHALL keep storage as a flat register array of DEPTH x DW, with no vendor RAM.

Verification
REQ-031 SHALL cover: reset, then in_valid=2'b11 with A,B for 1 cycle -> next cycle out_valid=2'b11, out_data={B,A}, count=2.
REQ-032 SHALL cover: 4 full groups (8 entries) with out_ready=0 -> count=8, in_ready=0, pause=1; a 5th group is ignored and count stays 8.
REQ-033 SHALL cover: buffer holds A,B and out_ready=2'b10 -> nothing dequeued, count unchanged; out_ready=2'b01 -> A leaves and B moves to lane 0.
REQ-034 SHALL cover: count=6, simultaneous enqueue of 2 and dequeue of 2 -> count=6; pointers wrap past 7 with ordering preserved over 20 random cycles against a reference FIFO.
REQ-035 SHALL cover: in_valid=2'b10 with X -> one entry, out_data[0]=X, count=1.
REQ-036 SHALL cover: flush asserted with count=5 and concurrent enqueue of 2 -> next cycle count=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: buffer geometry defaults and the
// decoded-instruction bundle carried through the decode buffer.
package decode_pkg;

  localparam int LANES_DEF = 2;
  localparam int DEPTH_DEF = 8;

  // One decoded instruction as handed from decode to issue.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] imm;
    logic        reg1_re;
    logic [4:0]  reg1_addr;
    logic        reg2_re;
    logic [4:0]  reg2_addr;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [2:0]  spare;      // pads the bundle to a 128-bit boundary
  } bundle_t;

  localparam int BUNDLE_W = $bits(bundle_t);

endpackage

// File: rtl/decode_buffer_lane_compact.sv
// Lane compaction: maps sparse per-lane enqueue requests onto consecutive
// write offsets (ascending lane order) and reports how many entries enqueue.
module lane_compact #(
  parameter int LANES = 2,
  parameter int ENQ_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]            in_valid,
  output logic [LANES-1:0][ENQ_W-1:0] lane_off,
  output logic [ENQ_W-1:0]            enq_num
);

  // Each lane's offset is the number of valid lanes below it.
  always_comb begin
    logic [ENQ_W-1:0] acc;
    acc      = '0;
    lane_off = '0;
    enq_num  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_off[i] = acc;
      if (in_valid[i]) acc = acc + ENQ_W'(1);
    end
    enq_num = acc;
  end

endmodule

// File: rtl/decode_buffer.sv
// Multi-lane decode buffer: a circular FIFO of decoded bundles that accepts
// up to LANES bundles per cycle (whole-group admission) and presents the
// oldest LANES entries in order, dequeuing an in-order accepted prefix.
module decode_buffer
  import decode_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = BUNDLE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [LANES-1:0]            in_valid,
  input  logic [LANES-1:0][DW-1:0]    in_data,
  output logic                        in_ready,
  output logic [LANES-1:0]            out_valid,
  output logic [LANES-1:0][DW-1:0]    out_data,
  input  logic [LANES-1:0]            out_ready,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        pause
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENQ_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

  logic [DW-1:0]               mem [DEPTH];
  logic [PTR_W-1:0]            rd_ptr;
  logic [PTR_W-1:0]            wr_ptr;
  logic [LANES-1:0][ENQ_W-1:0] lane_off;
  logic [ENQ_W-1:0]            enq_num;
  logic [CNT_W-1:0]            enq_cnt;
  logic [CNT_W-1:0]            deq_cnt;
  logic                        do_enq;

  lane_compact #(
    .LANES (LANES),
    .ENQ_W (ENQ_W)
  ) u_lane_compact (
    .in_valid (in_valid),
    .lane_off (lane_off),
    .enq_num  (enq_num)
  );

  // Admission depends only on registered occupancy, never on this cycle's dequeue.
  assign in_ready = (DEPTH_C - count) >= LANES_C;
  assign pause    = ~in_ready;
  assign do_enq   = in_ready && !flush && !rst;
  assign enq_cnt  = do_enq ? CNT_W'(enq_num) : '0;

  // Present the oldest LANES entries, oldest in lane 0.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      out_valid[i] = count > CNT_W'(i);
      out_data[i]  = mem[rd_ptr + PTR_W'(i)];
    end
  end

  // Dequeue only the contiguous accepted prefix starting at lane 0.
  always_comb begin
    logic stop;
    stop    = 1'b0;
    deq_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!stop && out_valid[i] && out_ready[i]) deq_cnt = deq_cnt + CNT_W'(1);
      else stop = 1'b1;
    end
  end

  // Storage writes: compacted lanes land at consecutive slots from wr_ptr.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valid[i]) mem[wr_ptr + PTR_W'(lane_off[i])] <= in_data[i];
      end
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats traffic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count + enq_cnt - deq_cnt;
      rd_ptr <= rd_ptr + PTR_W'(deq_cnt);
      wr_ptr <= wr_ptr + PTR_W'(enq_cnt);
    end
  end

endmodule

// File: tb/tb_decode_buffer.sv
// Directed bench for decode_buffer with a small queue reference model.
module tb_decode_buffer;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int DW    = 128;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flush;
  logic [LANES-1:0]         in_valid;
  logic [LANES-1:0][DW-1:0] in_data;
  logic                     in_ready;
  logic [LANES-1:0]         out_valid;
  logic [LANES-1:0][DW-1:0] out_data;
  logic [LANES-1:0]         out_ready;
  logic [3:0]               count;
  logic                     pause;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] ref_q [$];

  decode_buffer #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .pause     (pause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the reference model, then settle.
  task automatic cycle(input logic [LANES-1:0] v, input logic [LANES-1:0][DW-1:0] d,
                       input logic [LANES-1:0] r, input logic f, input logic rs);
    int  k;
    bit  stop;
    bit  acc;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    rst       = rs;
    if (rs || f) begin
      ref_q.delete();
    end else begin
      acc  = (DEPTH - ref_q.size()) >= LANES;
      k    = 0;
      stop = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        if (!stop && i < ref_q.size() && r[i]) k++;
        else stop = 1'b1;
      end
      for (int i = 0; i < k; i++) void'(ref_q.pop_front());
      if (acc) begin
        for (int i = 0; i < LANES; i++) if (v[i]) ref_q.push_back(d[i]);
      end
    end
    @(posedge clk);
    #1;
    in_valid  = '0;
    out_ready = '0;
    flush     = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, DW'(count), DW'(ref_q.size()));
    check({tag, "_in_ready"}, DW'(in_ready), DW'((DEPTH - ref_q.size()) >= LANES));
    for (int i = 0; i < LANES; i++) begin
      check({tag, "_out_valid"}, DW'(out_valid[i]), DW'(i < ref_q.size()));
      if (i < ref_q.size()) check({tag, "_out_data"}, out_data[i], ref_q[i]);
    end
  endtask

  localparam logic [DW-1:0] A    = 128'hAAAA_0001_0000_0000_0000_0000_0000_00A1;
  localparam logic [DW-1:0] B    = 128'hBBBB_0002_0000_0000_0000_0000_0000_00B2;
  localparam logic [DW-1:0] X    = 128'h5555_0003_0000_0000_0000_0000_0000_0055;
  localparam logic [DW-1:0] GBASE = 128'h6700_0000_0000_0000_0000_0000_0000_0000;

  initial begin
    logic [LANES-1:0][DW-1:0] d;
    rst = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_count", DW'(count), 128'd0);
    check("reset_out_valid", DW'(out_valid), 128'd0);
    check("reset_in_ready", DW'(in_ready), 128'd1);
    check("reset_pause", DW'(pause), 128'd0);

    // Two-lane enqueue, visible the following cycle
    d = {B, A};
    cycle(2'b11, d, 2'b00, 1'b0, 1'b0);
    check("pair_out_valid", DW'(out_valid), 128'd3);
    check("pair_lane0", out_data[0], A);
    check("pair_lane1", out_data[1], B);
    check("pair_count", DW'(count), 128'd2);

    // Ready on lane 1 only: nothing leaves
    cycle(2'b00, '0, 2'b10, 1'b0, 1'b0);
    check("hole_count", DW'(count), 128'd2);
    check("hole_lane0", out_data[0], A);
    // Ready on lane 0: A leaves, B moves down
    cycle(2'b00, '0, 2'b01, 1'b0, 1'b0);
    check("pop1_count", DW'(count), 128'd1);
    check("pop1_lane0", out_data[0], B);
    check("pop1_out_valid", DW'(out_valid), 128'd1);

    // Sparse lane 1 only enqueue
    cycle(2'b00, '0, 2'b00, 1'b1, 1'b0);
    d = {X, 128'hDEAD};
    cycle(2'b10, d, 2'b00, 1'b0, 1'b0);
    check("sparse_count", DW'(count), 128'd1);
    check("sparse_lane0", out_data[0], X);
    check("sparse_out_valid", DW'(out_valid), 128'd1);
    cycle(2'b00, '0, 2'b00, 1'b1, 1'b0);

    // Fill to DEPTH, then a fifth group must be refused
    for (int g = 0; g < 4; g++) begin
      d = {GBASE + DW'(2 * g + 1), GBASE + DW'(2 * g)};
      cycle(2'b11, d, 2'b00, 1'b0, 1'b0);
    end
    check("full_count", DW'(count), 128'd8);
    check("full_in_ready", DW'(in_ready), 128'd0);
    check("full_pause", DW'(pause), 128'd1);
    d = {128'hF00D, 128'hBEEF};
    cycle(2'b11, d, 2'b00, 1'b0, 1'b0);
    check("over_count", DW'(count), 128'd8);
    check("over_lane0", out_data[0], GBASE);
    check("over_lane1", out_data[1], GBASE + 128'd1);

    // Drain two while full (enqueue blocked), then enqueue 2 + dequeue 2
    d = {128'hF00D, 128'hBEEF};
    cycle(2'b11, d, 2'b11, 1'b0, 1'b0);
    check("drain_count", DW'(count), 128'd6);
    check("drain_lane0", out_data[0], GBASE + 128'd2);
    d = {GBASE + 128'd9, GBASE + 128'd8};
    cycle(2'b11, d, 2'b11, 1'b0, 1'b0);
    check("swap_count", DW'(count), 128'd6);
    check("swap_lane0", out_data[0], GBASE + 128'd4);
    check("swap_lane1", out_data[1], GBASE + 128'd5);

    // Random traffic across pointer wrap against the reference queue
    for (int c = 0; c < 20; c++) begin
      logic [LANES-1:0] rv;
      logic [LANES-1:0] rr;
      rv = LANES'($urandom_range(0, 3));
      rr = LANES'($urandom_range(0, 3));
      for (int i = 0; i < LANES; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
      cycle(rv, d, rr, 1'b0, 1'b0);
      check_model("rand");
    end

    // Flush at count 5 with a concurrent enqueue
    cycle(2'b00, '0, 2'b00, 1'b1, 1'b0);
    d = {B, A};
    cycle(2'b11, d, 2'b00, 1'b0, 1'b0);
    cycle(2'b11, d, 2'b00, 1'b0, 1'b0);
    cycle(2'b01, d, 2'b00, 1'b0, 1'b0);
    check("pre_flush_count", DW'(count), 128'd5);
    cycle(2'b11, d, 2'b11, 1'b1, 1'b0);
    check("flush_count", DW'(count), 128'd0);
    check("flush_out_valid", DW'(out_valid), 128'd0);
    check("flush_in_ready", DW'(in_ready), 128'd1);
    check("flush_pause", DW'(pause), 128'd0);

    // Reset mid-operation with concurrent traffic discards everything
    cycle(2'b11, d, 2'b00, 1'b0, 1'b0);
    check("pre_rst_count", DW'(count), 128'd2);
    cycle(2'b11, d, 2'b11, 1'b1, 1'b1);
    check("rst_count", DW'(count), 128'd0);
    check("rst_out_valid", DW'(out_valid), 128'd0);
    check("rst_in_ready", DW'(in_ready), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
